// File: rtl/msgpu_psram_arbiter.sv
// Two-requester arbiter in front of the QSPI PSRAM controller: display burst reads beat MCU byte writes.
// Optional MCU anti-starvation forced grant is enabled by defining MSGPU_ARB_ANTI_STARVE_EN.
module msgpu_psram_arbiter #(
    parameter int ADDR_W   = 23,
    parameter int LEN_W    = 10,
    parameter int MAX_WAIT = 64,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [LEN_W-1:0]  disp_len,
    output logic              disp_ack,
    output logic [7:0]        disp_rdata,
    output logic              disp_rdata_vld,
    input  logic              mcu_req,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [7:0]        mcu_wdata,
    output logic              mcu_ack,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LEN_W-1:0]  mem_len,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rdata_vld,
    input  logic              mem_done,
    output logic              arb_err
);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_MCU} owner_t;

    state_t             state_q;
    owner_t             owner_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               disp_ack_q;
    logic               mcu_ack_q;
    logic [7:0]         disp_rdata_q;
    logic               disp_rdata_vld_q;
    logic               mem_req_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [LEN_W-1:0]   mem_len_q;
    logic [7:0]         mem_wdata_q;
    logic               arb_err_q;
    logic               forced_mcu;
    logic               arb_open;
    logic               pick_mcu;

`ifdef MSGPU_ARB_ANTI_STARVE_EN
    logic [WAIT_W-1:0] mcu_wait_q;
    logic [WAIT_W-1:0] mcu_wait_d;

    always_comb begin
        mcu_wait_d = mcu_wait_q;
        if (!mcu_req || mcu_ack_q) begin
            mcu_wait_d = '0;
        end else if (mcu_wait_q != WAIT_W'(MAX_WAIT)) begin
            mcu_wait_d = mcu_wait_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mcu_wait_q <= '0;
        end else begin
            mcu_wait_q <= mcu_wait_d;
        end
    end

    assign forced_mcu = mcu_req && (mcu_wait_q == WAIT_W'(MAX_WAIT));
`else
    assign forced_mcu = 1'b0;
`endif

    // Requesters still see their own ack this cycle and have not yet dropped req; skip arbitration then.
    assign arb_open = !disp_ack_q && !mcu_ack_q;
    assign pick_mcu = mcu_req && (forced_mcu || !disp_req);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            owner_q          <= OWN_NONE;
            tmo_q            <= '0;
            disp_ack_q       <= 1'b0;
            mcu_ack_q        <= 1'b0;
            disp_rdata_q     <= '0;
            disp_rdata_vld_q <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_len_q        <= '0;
            mem_wdata_q      <= '0;
            arb_err_q        <= 1'b0;
        end else begin
            disp_ack_q       <= 1'b0;
            mcu_ack_q        <= 1'b0;
            disp_rdata_vld_q <= 1'b0;

            if (mem_rdata_vld) begin
                if (state_q == S_BUSY && owner_q == OWN_DISP) begin
                    disp_rdata_q     <= mem_rdata;
                    disp_rdata_vld_q <= 1'b1;
                end else begin
                    arb_err_q <= 1'b1;
                end
            end

            if (mem_done && state_q != S_BUSY) begin
                arb_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (arb_open) begin
                        if (pick_mcu) begin
                            mem_req_q   <= 1'b1;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= mcu_addr;
                            mem_len_q   <= LEN_W'(1);
                            mem_wdata_q <= mcu_wdata;
                            owner_q     <= OWN_MCU;
                            state_q     <= S_ISSUE;
                        end else if (disp_req) begin
                            if (disp_len == '0) begin
                                disp_ack_q <= 1'b1;
                            end else begin
                                mem_req_q   <= 1'b1;
                                mem_write_q <= 1'b0;
                                mem_addr_q  <= disp_addr;
                                mem_len_q   <= disp_len;
                                mem_wdata_q <= '0;
                                owner_q     <= OWN_DISP;
                                state_q     <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_req_q  <= 1'b0;
                        disp_ack_q <= (owner_q == OWN_DISP);
                        mcu_ack_q  <= (owner_q == OWN_MCU);
                        tmo_q      <= '0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_done) begin
                        owner_q <= OWN_NONE;
                        state_q <= S_IDLE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        owner_q   <= OWN_NONE;
                        state_q   <= S_IDLE;
                        arb_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign disp_ack       = disp_ack_q;
    assign mcu_ack        = mcu_ack_q;
    assign disp_rdata     = disp_rdata_q;
    assign disp_rdata_vld = disp_rdata_vld_q;
    assign mem_req        = mem_req_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_len        = mem_len_q;
    assign mem_wdata      = mem_wdata_q;
    assign arb_err        = arb_err_q;

endmodule

// File: tb/tb_msgpu_psram_arbiter.sv
// Directed bench for msgpu_psram_arbiter; the starvation scenario follows MSGPU_ARB_ANTI_STARVE_EN.
module tb_msgpu_psram_arbiter;
    localparam int ADDR_W   = 23;
    localparam int LEN_W    = 10;
    localparam int MAX_WAIT = 64;
    localparam int TIMEOUT  = 4096;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [LEN_W-1:0]  disp_len;
    logic              disp_ack;
    logic [7:0]        disp_rdata;
    logic              disp_rdata_vld;
    logic              mcu_req;
    logic [ADDR_W-1:0] mcu_addr;
    logic [7:0]        mcu_wdata;
    logic              mcu_ack;
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic [7:0]        mem_rdata;
    logic              mem_rdata_vld;
    logic              mem_done;
    logic              arb_err;

    int checks   = 0;
    int failures = 0;

    msgpu_psram_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .disp_rdata_vld(disp_rdata_vld),
        .mcu_req(mcu_req), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata), .mcu_ack(mcu_ack),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rdata_vld(mem_rdata_vld), .mem_done(mem_done), .arb_err(arb_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        disp_req = 1'b0; disp_addr = '0; disp_len = '0;
        mcu_req = 1'b0; mcu_addr = '0; mcu_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0; mem_rdata_vld = 1'b0; mem_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        checks++;
        if ({disp_ack, disp_rdata_vld, mcu_ack, mem_req, mem_write, arb_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000000", {disp_ack, disp_rdata_vld, mcu_ack, mem_req, mem_write, arb_err});
        end
        checks++;
        if ({disp_rdata, mem_addr, mem_len, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h addr=%h len=%0d wdata=%h want all 0", disp_rdata, mem_addr, mem_len, mem_wdata);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_disp_burst();
        int bad;
        int fwd;
        logic [7:0] exp_b;
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h000100; disp_len = 10'd640; mem_ready = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_write, mem_addr, mem_len, disp_ack} !== {1'b1, 1'b0, 23'h000100, 10'd640, 1'b0}) begin
            failures++;
            $display("FAIL burst_cmd: req=%b wr=%b addr=%h len=%0d ack=%b want 1 0 000100 640 0", mem_req, mem_write, mem_addr, mem_len, disp_ack);
        end
        step();
        checks++;
        if ({disp_ack, mcu_ack, mem_req} !== 3'b100) begin
            failures++;
            $display("FAIL burst_ack: disp_ack=%b mcu_ack=%b mem_req=%b want 1 0 0", disp_ack, mcu_ack, mem_req);
        end
        disp_req = 1'b0;
        step();
        checks++;
        if (disp_ack !== 1'b0) begin
            failures++;
            $display("FAIL burst_ack_width: disp_ack=%b want 0", disp_ack);
        end
        bad = 0;
        fwd = 0;
        for (int i = 0; i < 640; i++) begin
            exp_b = 8'(i * 7 + 3);
            mem_rdata_vld = 1'b1;
            mem_rdata = exp_b;
            step();
            if (disp_rdata_vld === 1'b1 && disp_rdata === exp_b) fwd++;
            else bad++;
            if (i % 8 == 7) begin
                mem_rdata_vld = 1'b0;
                mem_rdata = 8'hEE;
                step();
                if (disp_rdata_vld !== 1'b0) bad++;
            end
        end
        mem_rdata_vld = 1'b0;
        checks++;
        if (bad != 0 || fwd != 640) begin
            failures++;
            $display("FAIL burst_stream: forwarded=%0d errors=%0d want 640 and 0", fwd, bad);
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        checks++;
        if ({disp_rdata_vld, arb_err} !== 2'b00) begin
            failures++;
            $display("FAIL burst_done: vld=%b arb_err=%b want 0 0", disp_rdata_vld, arb_err);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h002000; disp_len = 10'd4;
        mcu_req = 1'b1; mcu_addr = 23'h7ABCDE; mcu_wdata = 8'hA5;
        mem_ready = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_write, mem_addr} !== {1'b1, 1'b0, 23'h002000}) begin
            failures++;
            $display("FAIL simul_first: req=%b wr=%b addr=%h want 1 0 002000", mem_req, mem_write, mem_addr);
        end
        step();
        checks++;
        if ({disp_ack, mcu_ack} !== 2'b10) begin
            failures++;
            $display("FAIL simul_disp_ack: disp_ack=%b mcu_ack=%b want 1 0", disp_ack, mcu_ack);
        end
        disp_req = 1'b0;
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL simul_gap: mem_req=%b want 0 one cycle after mem_done", mem_req);
        end
        step();
        checks++;
        if ({mem_req, mem_write, mem_addr, mem_len, mem_wdata} !== {1'b1, 1'b1, 23'h7ABCDE, 10'd1, 8'hA5}) begin
            failures++;
            $display("FAIL simul_mcu_cmd: req=%b wr=%b addr=%h len=%0d wdata=%h want 1 1 7abcde 1 a5", mem_req, mem_write, mem_addr, mem_len, mem_wdata);
        end
        step();
        checks++;
        if ({mcu_ack, disp_ack, mem_req} !== 3'b100) begin
            failures++;
            $display("FAIL simul_mcu_ack: mcu_ack=%b disp_ack=%b mem_req=%b want 1 0 0", mcu_ack, disp_ack, mem_req);
        end
        mcu_req = 1'b0;
        mem_rdata_vld = 1'b1;
        mem_rdata = 8'h33;
        step();
        mem_rdata_vld = 1'b0;
        checks++;
        if ({mcu_ack, disp_rdata_vld, arb_err} !== 3'b001) begin
            failures++;
            $display("FAIL simul_stray_rdata: mcu_ack=%b vld=%b arb_err=%b want 0 0 1", mcu_ack, disp_rdata_vld, arb_err);
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
    endtask

    task automatic test_ready_stall();
        int bad;
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h0155AA; disp_len = 10'd16; mem_ready = 1'b0;
        step();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if ({mem_req, mem_write, mem_addr, mem_len, disp_ack} !== {1'b1, 1'b0, 23'h0155AA, 10'd16, 1'b0}) bad++;
            if (k == 2) disp_req = 1'b0;
            if (k < 9) step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable cycles out of 10, want 0", bad);
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if ({disp_ack, mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL stall_accept: disp_ack=%b mem_req=%b want 1 0", disp_ack, mem_req);
        end
        step();
        checks++;
        if ({disp_ack, mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL stall_after: disp_ack=%b mem_req=%b want 0 0", disp_ack, mem_req);
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
    endtask

    task automatic test_len_zero();
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h000040; disp_len = 10'd0; mem_ready = 1'b1;
        step();
        checks++;
        if ({disp_ack, mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL len0_ack: disp_ack=%b mem_req=%b want 1 0", disp_ack, mem_req);
        end
        disp_req = 1'b0;
        step();
        checks++;
        if ({disp_ack, mem_req, arb_err} !== 3'b000) begin
            failures++;
            $display("FAIL len0_after: disp_ack=%b mem_req=%b arb_err=%b want 0 0 0", disp_ack, mem_req, arb_err);
        end
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        checks++;
        if ({mem_req, arb_err} !== 2'b01) begin
            failures++;
            $display("FAIL idle_done_err: mem_req=%b arb_err=%b want 0 1", mem_req, arb_err);
        end
        step();
        checks++;
        if (arb_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: arb_err=%b want 1", arb_err);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h000300; disp_len = 10'd8; mem_ready = 1'b1;
        step();
        step();
        disp_req = 1'b0;
        mem_rdata_vld = 1'b1;
        mem_rdata = 8'h99;
        step();
        checks++;
        if ({disp_rdata_vld, disp_rdata} !== {1'b1, 8'h99}) begin
            failures++;
            $display("FAIL busy_fwd: vld=%b rdata=%h want 1 99", disp_rdata_vld, disp_rdata);
        end
        mem_rdata = 8'h77;
        reset_n = 1'b0;
        step();
        checks++;
        if ({disp_ack, disp_rdata_vld, disp_rdata, mcu_ack, mem_req, mem_write, mem_addr, mem_len, mem_wdata, arb_err} !== '0) begin
            failures++;
            $display("FAIL midbusy_reset: vld=%b rdata=%h req=%b addr=%h len=%0d err=%b want all 0", disp_rdata_vld, disp_rdata, mem_req, mem_addr, mem_len, arb_err);
        end
        reset_n = 1'b1;
        mem_rdata_vld = 1'b0;
        mcu_req = 1'b1; mcu_addr = 23'h000123; mcu_wdata = 8'h5C;
        step();
        checks++;
        if ({mem_req, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 23'h000123, 8'h5C}) begin
            failures++;
            $display("FAIL midbusy_idle: req=%b wr=%b addr=%h wdata=%h want 1 1 000123 5c", mem_req, mem_write, mem_addr, mem_wdata);
        end
        step();
        mcu_req = 1'b0;
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h000500; disp_len = 10'd4; mem_ready = 1'b1;
        step();
        step();
        checks++;
        if (disp_ack !== 1'b1) begin
            failures++;
            $display("FAIL tmo_ack: disp_ack=%b want 1", disp_ack);
        end
        disp_req = 1'b0;
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            if (arb_err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL tmo_early: arb_err high on %0d cycles before timeout, want 0", early);
        end
        step();
        checks++;
        if (arb_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_abort: arb_err=%b want 1 after %0d BUSY cycles", arb_err, TIMEOUT);
        end
        mcu_req = 1'b1; mcu_addr = 23'h000777; mcu_wdata = 8'h01;
        step();
        checks++;
        if ({mem_req, mem_write, mem_addr} !== {1'b1, 1'b1, 23'h000777}) begin
            failures++;
            $display("FAIL tmo_idle: req=%b wr=%b addr=%h want 1 1 000777", mem_req, mem_write, mem_addr);
        end
        step();
        mcu_req = 1'b0;
    endtask

    task automatic test_starvation();
        int grant_cyc;
        int mcu_acks;
        int disp_acks;
        int both;
        do_reset();
        disp_req = 1'b1; disp_addr = 23'h000800; disp_len = 10'd1;
        mcu_req = 1'b1; mcu_addr = 23'h000042; mcu_wdata = 8'h11;
        mem_ready = 1'b1;
        grant_cyc = -1;
        mcu_acks = 0;
        disp_acks = 0;
        both = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (mem_req === 1'b1 && mem_write === 1'b1 && grant_cyc < 0) grant_cyc = c;
            if (disp_ack === 1'b1 && mcu_ack === 1'b1) both++;
            if (disp_ack === 1'b1) disp_acks++;
            if (mcu_ack === 1'b1) begin
                mcu_acks++;
                mcu_req = 1'b0;
            end
            mem_done = (disp_ack === 1'b1 || mcu_ack === 1'b1);
        end
        mem_done = 1'b0;
        checks++;
        if (both != 0 || disp_acks < 30) begin
            failures++;
            $display("FAIL starve_disp: dual acks=%0d display acks=%0d want 0 and >=30", both, disp_acks);
        end
`ifdef MSGPU_ARB_ANTI_STARVE_EN
        checks++;
        if (grant_cyc < MAX_WAIT || grant_cyc > MAX_WAIT + 8 || mcu_acks != 1) begin
            failures++;
            $display("FAIL starve_forced: grant cycle=%0d acks=%0d want %0d..%0d and 1", grant_cyc, mcu_acks, MAX_WAIT, MAX_WAIT + 8);
        end
`else
        checks++;
        if (grant_cyc != -1 || mcu_acks != 0) begin
            failures++;
            $display("FAIL starve_strict: grant cycle=%0d acks=%0d want -1 and 0", grant_cyc, mcu_acks);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_disp_burst();
        test_simultaneous();
        test_ready_stall();
        test_len_zero();
        test_reset_mid_busy();
        test_timeout();
        test_starvation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
